// File: rtl/vending_pkg.sv
// Shared vending-machine constants and types: coin denominations, item prices,
// coin index and change-dispenser state encoding.
package vending_pkg;

    localparam logic [7:0] COIN_50 = 8'd50;
    localparam logic [7:0] COIN_20 = 8'd20;
    localparam logic [7:0] COIN_10 = 8'd10;
    localparam logic [7:0] COIN_1  = 8'd1;

    localparam logic [7:0] PRICE_WATER = 8'd40;
    localparam logic [7:0] PRICE_COLA  = 8'd65;
    localparam logic [7:0] PRICE_SNACK = 8'd85;
    localparam logic [7:0] PRICE_CANDY = 8'd25;

    localparam logic [7:0] INIT_STOCK_DEF = 8'd20;

    typedef logic [1:0] coin_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEL   = 2'd1,
        ST_EJECT = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_e;

endpackage

// File: rtl/coin_select.sv
// Combinational largest-first coin picker: lowest eligible index whose
// denomination still fits in the remaining amount.
module coin_select (
    input  logic [7:0] remaining,
    input  logic [7:0] coin_0,
    input  logic [7:0] coin_1,
    input  logic [7:0] coin_2,
    input  logic [7:0] coin_3,
    input  logic [3:0] eligible,
    output logic       found,
    output logic [1:0] index
);

    always_comb begin
        found = 1'b0;
        index = 2'd0;
        if (eligible[0] && (coin_0 <= remaining)) begin
            found = 1'b1;
            index = 2'd0;
        end else if (eligible[1] && (coin_1 <= remaining)) begin
            found = 1'b1;
            index = 2'd1;
        end else if (eligible[2] && (coin_2 <= remaining)) begin
            found = 1'b1;
            index = 2'd2;
        end else if (eligible[3] && (coin_3 <= remaining)) begin
            found = 1'b1;
            index = 2'd3;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change-return back end: accepts an amount, ejects coins largest-first over a
// req/ack handshake, then reports coins paid and unpayable residual.
// Optional per-denomination coin stock tracking is enabled by COIN_STOCK_EN.
module change_dispenser
    import vending_pkg::*;
#(
    parameter logic [7:0] COIN_0 = COIN_50,
    parameter logic [7:0] COIN_1 = COIN_20,
    parameter logic [7:0] COIN_2 = COIN_10,
    parameter logic [7:0] COIN_3 = vending_pkg::COIN_1
`ifdef COIN_STOCK_EN
    ,
    parameter logic [7:0] INIT_STOCK = INIT_STOCK_DEF
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       change_valid,
    input  logic [7:0] change_amount,
    output logic       change_ready,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    input  logic       coin_ack,
    output logic       change_done,
    output logic [7:0] coins_paid,
    output logic [7:0] residual
`ifdef COIN_STOCK_EN
    ,
    input  logic       stock_load,
    input  logic [1:0] stock_sel,
    input  logic [7:0] stock_count
`endif
);

    localparam logic [1:0] IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] SEL   = 2'(ST_SEL);
    localparam logic [1:0] EJECT = 2'(ST_EJECT);
    localparam logic [1:0] DONE  = 2'(ST_DONE);

    logic [1:0] state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    logic       change_ready_d;
    logic       coin_req_d;
    logic [1:0] coin_sel_d;
    logic       change_done_d;
    logic [7:0] coins_paid_d;
    logic [7:0] residual_d;
    logic [3:0] eligible_c;
    logic       sel_found_c;
    logic [1:0] sel_idx_c;
    logic [7:0] coin_val_c;

    coin_select u_coin_select (
        .remaining (remaining_q),
        .coin_0    (COIN_0),
        .coin_1    (COIN_1),
        .coin_2    (COIN_2),
        .coin_3    (COIN_3),
        .eligible  (eligible_c),
        .found     (sel_found_c),
        .index     (sel_idx_c)
    );

    // Value of the coin currently being ejected.
    always_comb begin
        case (coin_sel)
            2'd0:    coin_val_c = COIN_0;
            2'd1:    coin_val_c = COIN_1;
            2'd2:    coin_val_c = COIN_2;
            default: coin_val_c = COIN_3;
        endcase
    end

`ifdef COIN_STOCK_EN
    logic [3:0][7:0] stock_q;
    logic            take_coin_c;

    assign take_coin_c = (state_q == EJECT) && coin_ack;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eligible_c[i] = (stock_q[i] != 8'd0);
        end
    end

    // Load is applied after the decrement so it wins on the same counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= INIT_STOCK;
            end
        end else begin
            if (take_coin_c && (stock_q[coin_sel] != 8'd0)) begin
                stock_q[coin_sel] <= stock_q[coin_sel] - 8'd1;
            end
            if (stock_load) begin
                stock_q[stock_sel] <= stock_count;
            end
        end
    end
`else
    assign eligible_c = 4'b1111;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        coin_req_d    = coin_req;
        coin_sel_d    = coin_sel;
        change_done_d = 1'b0;
        coins_paid_d  = coins_paid;
        residual_d    = residual;
        case (state_q)
            IDLE: begin
                if (change_valid) begin
                    remaining_d  = change_amount;
                    coins_paid_d = 8'd0;
                    residual_d   = 8'd0;
                    state_d      = SEL;
                end
            end
            SEL: begin
                if (sel_found_c) begin
                    coin_sel_d = sel_idx_c;
                    coin_req_d = 1'b1;
                    state_d    = EJECT;
                end else begin
                    residual_d    = remaining_q;
                    change_done_d = 1'b1;
                    state_d       = DONE;
                end
            end
            EJECT: begin
                if (coin_ack) begin
                    coin_req_d   = 1'b0;
                    remaining_d  = remaining_q - coin_val_c;
                    coins_paid_d = (coins_paid == 8'hFF) ? coins_paid : coins_paid + 8'd1;
                    state_d      = SEL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        change_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            remaining_q  <= 8'd0;
            change_ready <= 1'b1;
            coin_req     <= 1'b0;
            coin_sel     <= 2'd0;
            change_done  <= 1'b0;
            coins_paid   <= 8'd0;
            residual     <= 8'd0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            change_ready <= change_ready_d;
            coin_req     <= coin_req_d;
            coin_sel     <= coin_sel_d;
            change_done  <= change_done_d;
            coins_paid   <= coins_paid_d;
            residual     <= residual_d;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy arithmetic reference model
// queues expected coins and results; a monitor compares as the DUT presents them.
module tb_change_dispenser;

    logic       clk;
    logic       reset_n;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       change_ready;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       coin_ack;
    logic       change_done;
    logic [7:0] coins_paid;
    logic [7:0] residual;
`ifdef COIN_STOCK_EN
    logic       stock_load;
    logic [1:0] stock_sel;
    logic [7:0] stock_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int ack_mode = 0;          // 0 random, 1 hold low while requested, 2 immediate
    int den[4] = '{50, 20, 10, 1};
    int ref_stock[4] = '{20, 20, 20, 20};
    int sel_q[$];
    int exp_paid_q[$];
    int exp_res_q[$];

    change_dispenser dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .change_ready  (change_ready),
        .coin_req      (coin_req),
        .coin_sel      (coin_sel),
        .coin_ack      (coin_ack),
        .change_done   (change_done),
        .coins_paid    (coins_paid),
        .residual      (residual)
`ifdef COIN_STOCK_EN
        ,
        .stock_load    (stock_load),
        .stock_sel     (stock_sel),
        .stock_count   (stock_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Greedy payout with plain division; stock caps each denomination.
    task automatic model_push(input int amount);
        int rem;
        int n;
        int paid;
        rem  = amount;
        paid = 0;
        for (int i = 0; i < 4; i++) begin
            n = rem / den[i];
`ifdef COIN_STOCK_EN
            if (n > ref_stock[i]) n = ref_stock[i];
            ref_stock[i] -= n;
`endif
            for (int k = 0; k < n; k++) sel_q.push_back(i);
            rem  -= n * den[i];
            paid += n;
        end
        exp_paid_q.push_back(paid > 255 ? 255 : paid);
        exp_res_q.push_back(rem);
    endtask

    // Coin mechanism: acknowledge timing chosen by ack_mode, spurious acks when idle.
    initial begin
        coin_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (coin_req) begin
                case (ack_mode)
                    1:       coin_ack = 1'b0;
                    2:       coin_ack = 1'b1;
                    default: coin_ack = ($urandom_range(0, 2) == 0);
                endcase
            end else begin
                coin_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: coin handshakes, request stability, completion results.
    initial begin
        logic       prev_stall;
        logic [1:0] prev_sel;
        logic       prev_done;
        prev_stall = 1'b0;
        prev_sel   = 2'd0;
        prev_done  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("stall_req", int'(coin_req), 1);
                check("stall_sel", int'(coin_sel), int'(prev_sel));
            end
            if (coin_req && coin_ack) begin
                if (sel_q.size() == 0) flag("unexpected coin");
                else check("coin_sel", int'(coin_sel), sel_q.pop_front());
            end
            prev_stall = coin_req && !coin_ack;
            prev_sel   = coin_sel;
            if (change_done) begin
                check("done_width", int'(prev_done), 0);
                if (exp_paid_q.size() == 0) begin
                    flag("unexpected change_done");
                end else begin
                    check("coins_paid", int'(coins_paid), exp_paid_q.pop_front());
                    check("residual", int'(residual), exp_res_q.pop_front());
                end
            end
            prev_done = change_done;
        end
    end

    task automatic send(input int amt, input bit push);
        int t;
        t = 0;
        while (!change_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!change_ready) flag("change_ready timeout");
        if (push) model_push(amt);
        change_valid  = 1'b1;
        change_amount = 8'(amt);
        @(negedge clk);
        change_valid  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!(exp_paid_q.size() == 0 && change_ready) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (exp_paid_q.size() != 0) flag("payout timeout");
        @(negedge clk);
    endtask

    task automatic wait_req();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!coin_req && t < 200);
        if (!coin_req) flag("coin_req timeout");
    endtask

`ifdef COIN_STOCK_EN
    task automatic load_stock(input int sel, input int cnt);
        stock_load  = 1'b1;
        stock_sel   = 2'(sel);
        stock_count = 8'(cnt);
        @(negedge clk);
        stock_load  = 1'b0;
        ref_stock[sel] = cnt;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n       = 1'b0;
        change_valid  = 1'b0;
        change_amount = 8'd0;
`ifdef COIN_STOCK_EN
        stock_load    = 1'b0;
        stock_sel     = 2'd0;
        stock_count   = 8'd0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", int'(change_ready), 1);
        check("rst_req", int'(coin_req), 0);
        check("rst_sel", int'(coin_sel), 0);
        check("rst_done", int'(change_done), 0);
        check("rst_paid", int'(coins_paid), 0);
        check("rst_resid", int'(residual), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 85 with one-cycle acks
        ack_mode = 2;
        send(85, 1'b1);
        wait_done();
        check("p85_paid", int'(coins_paid), 8);
        check("p85_resid", int'(residual), 0);

        // zero amount: done in the second cycle after acceptance
        send(0, 1'b1);
        #1;
        check("z_done_c1", int'(change_done), 0);
        check("z_ready_c1", int'(change_ready), 0);
        @(negedge clk);
        #1;
        check("z_done_c2", int'(change_done), 1);
        check("z_req_c2", int'(coin_req), 0);
        @(negedge clk);
        #1;
        check("z_ready_c3", int'(change_ready), 1);
        check("z_done_c3", int'(change_done), 0);
        wait_done();

        // 70 with a six-cycle stall on the first coin and a busy-time request
        ack_mode = 1;
        send(70, 1'b1);
        wait_req();
        for (int c = 0; c < 6; c++) begin
            change_valid  = (c == 2);
            change_amount = 8'd30;
            @(negedge clk);
            #1;
            check("stall_hold_req", int'(coin_req), 1);
            check("stall_hold_sel", int'(coin_sel), 0);
        end
        change_valid = 1'b0;
        ack_mode = 0;
        wait_done();
        check("p70_paid", int'(coins_paid), 2);

        // 255 with random ack latency
        send(255, 1'b1);
        wait_done();
        check("p255_paid", int'(coins_paid), 10);
        check("p255_resid", int'(residual), 0);

        // random amounts
        for (int r = 0; r < 25; r++) begin
            ack_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            send($urandom_range(0, 255), 1'b1);
            wait_done();
        end

        // 200 with reset during the second coin eject
        ack_mode = 1;
        sel_q.push_back(0);
        send(200, 1'b0);
        wait_req();
        ack_mode = 2;
        @(negedge clk);
        ack_mode = 1;
        wait_req();
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", int'(coin_req), 0);
        check("mid_rst_ready", int'(change_ready), 1);
        check("mid_rst_paid", int'(coins_paid), 0);
        check("mid_rst_coins_left", sel_q.size(), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ack_mode = 0;
        @(negedge clk);
        #1;
        check("post_rst_paid", int'(coins_paid), 0);
        check("post_rst_resid", int'(residual), 0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) ref_stock[i] = 20;
        send(10, 1'b1);
        wait_done();
        check("p10_paid", int'(coins_paid), 1);

`ifdef COIN_STOCK_EN
        // exhausted large coins: 43 paid as 10x4, 1x2, residual 1
        load_stock(0, 0);
        load_stock(1, 0);
        load_stock(2, 20);
        load_stock(3, 2);
        send(43, 1'b1);
        wait_done();
        check("stk_paid", int'(coins_paid), 6);
        check("stk_resid", int'(residual), 1);
`endif

        check("coins_outstanding", sel_q.size(), 0);
        check("results_outstanding", exp_paid_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
